// File: rtl/avg_window_sink_pkg.sv
// Shared constants and state type for the windowed max/min sink.
package avg_window_sink_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    R_WAIT = 2'd0,
    R_ACK  = 2'd1,
    O_PRES = 2'd2,
    O_DONE = 2'd3
  } state_t;

  localparam logic DAV_ACTIVE = 1'b0;
  localparam logic RFD_READY  = 1'b1;

endpackage

// File: rtl/avg_window_sink_minmax_upd.sv
// Running max/min update; the first sample of a window seeds both values.
module minmax_upd
  import avg_window_sink_pkg::*;
(
  input  logic [DATA_W-1:0] cur_max,
  input  logic [DATA_W-1:0] cur_min,
  input  logic [DATA_W-1:0] sample,
  input  logic              first,
  output logic [DATA_W-1:0] new_max,
  output logic [DATA_W-1:0] new_min
);

  always_comb begin
    new_max = cur_max;
    new_min = cur_min;
    if (first) begin
      new_max = sample;
      new_min = sample;
    end else begin
      if (sample > cur_max) new_max = sample;
      if (sample < cur_min) new_min = sample;
    end
  end

endmodule

// File: rtl/avg_window_sink.sv
// Collects W samples over the dav_/rfd handshake and presents max, min and
// span downstream on a second dav_/rfd handshake.
module avg_window_sink
  import avg_window_sink_pkg::*;
#(
  parameter int unsigned W = 4
)
(
  input  logic              clock,
  input  logic              reset_,
  input  logic              dav_,
  input  logic [DATA_W-1:0] avg,
  output logic              rfd,
  output logic              dav_out_,
  input  logic              rfd_out,
  output logic [DATA_W-1:0] max_o,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] span_o
);

  localparam logic [4:0] CNT_FULL = 5'(W);

  state_t            state, state_nx;
  logic [4:0]        cnt, cnt_nx;
  logic [DATA_W-1:0] run_max, run_min, run_max_nx, run_min_nx;
  logic [DATA_W-1:0] upd_max, upd_min;
  logic [DATA_W-1:0] max_nx, min_nx, span_nx;
  logic              rfd_nx, dav_out_nx;
  logic              first_smp;

  assign first_smp = (cnt == '0);

  minmax_upd u_minmax (
    .cur_max (run_max),
    .cur_min (run_min),
    .sample  (avg),
    .first   (first_smp),
    .new_max (upd_max),
    .new_min (upd_min)
  );

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state    <= R_WAIT;
      cnt      <= '0;
      run_max  <= '0;
      run_min  <= '0;
      rfd      <= RFD_READY;
      dav_out_ <= ~DAV_ACTIVE;
      max_o    <= '0;
      min_o    <= '0;
      span_o   <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      run_max  <= run_max_nx;
      run_min  <= run_min_nx;
      rfd      <= rfd_nx;
      dav_out_ <= dav_out_nx;
      max_o    <= max_nx;
      min_o    <= min_nx;
      span_o   <= span_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    run_max_nx = run_max;
    run_min_nx = run_min;
    rfd_nx     = rfd;
    dav_out_nx = dav_out_;
    max_nx     = max_o;
    min_nx     = min_o;
    span_nx    = span_o;
    case (state)
      R_WAIT: begin
        if (dav_ == DAV_ACTIVE) begin
          run_max_nx = upd_max;
          run_min_nx = upd_min;
          cnt_nx     = cnt + 5'd1;
          rfd_nx     = ~RFD_READY;
          state_nx   = R_ACK;
        end
      end
      R_ACK: begin
        if (dav_ != DAV_ACTIVE) begin
          if (cnt == CNT_FULL) begin
            max_nx     = run_max;
            min_nx     = run_min;
            span_nx    = run_max - run_min;
            dav_out_nx = DAV_ACTIVE;
            state_nx   = O_PRES;
          end else begin
            rfd_nx   = RFD_READY;
            state_nx = R_WAIT;
          end
        end
      end
      O_PRES: begin
        if (rfd_out != RFD_READY) begin
          dav_out_nx = ~DAV_ACTIVE;
          state_nx   = O_DONE;
        end
      end
      O_DONE: begin
        // Window count is cleared only once downstream has fully released.
        if (rfd_out == RFD_READY) begin
          cnt_nx   = '0;
          rfd_nx   = RFD_READY;
          state_nx = R_WAIT;
        end
      end
      default: state_nx = R_WAIT;
    endcase
  end

endmodule

// File: tb/tb_avg_window_sink.sv
// Randomized bench for avg_window_sink (W=4 and W=1 instances) against a
// window-level max/min reference model.
module tb_avg_window_sink;

  localparam int unsigned W0 = 4;
  localparam int unsigned W1 = 1;

  logic            clock = 1'b0;
  logic            reset_;
  logic [1:0]      dav_n;
  logic [1:0][7:0] avg_s;
  logic [1:0]      rfd_w;
  logic [1:0]      dav_out_w;
  logic [1:0]      rfd_out_s;
  logic [1:0][7:0] max_w, min_w, span_w;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  win [2][16];
  int unsigned n_win [2];
  logic [7:0]  exp_max [2];
  logic [7:0]  exp_min [2];
  logic [7:0]  exp_span [2];

  always #5 clock = ~clock;

  avg_window_sink #(.W(W0)) u_dut4 (
    .clock(clock), .reset_(reset_), .dav_(dav_n[0]), .avg(avg_s[0]),
    .rfd(rfd_w[0]), .dav_out_(dav_out_w[0]), .rfd_out(rfd_out_s[0]),
    .max_o(max_w[0]), .min_o(min_w[0]), .span_o(span_w[0])
  );

  avg_window_sink #(.W(W1)) u_dut1 (
    .clock(clock), .reset_(reset_), .dav_(dav_n[1]), .avg(avg_s[1]),
    .rfd(rfd_w[1]), .dav_out_(dav_out_w[1]), .rfd_out(rfd_out_s[1]),
    .max_o(max_w[1]), .min_o(min_w[1]), .span_o(span_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  function automatic int unsigned wof(input int idx);
    return (idx == 0) ? W0 : W1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n_win[i]    = 0;
      exp_max[i]  = '0;
      exp_min[i]  = '0;
      exp_span[i] = '0;
    end
  endtask

  task automatic chk_outs(input int idx);
    chk("max_o", max_w[idx], exp_max[idx]);
    chk("min_o", min_w[idx], exp_min[idx]);
    chk("span_o", span_w[idx], exp_span[idx]);
  endtask

  task automatic send(input int idx, input logic [7:0] val, input int unsigned hold);
    int unsigned t;
    logic [7:0]  mx, mn;
    t = 0;
    while (rfd_w[idx] !== 1'b1 && t < 50) begin
      cyc();
      t++;
    end
    chk("rfd_ready", rfd_w[idx], 1'b1);
    dav_n[idx] = 1'b0;
    avg_s[idx] = val;
    for (int unsigned h = 0; h < hold; h++) begin
      cyc();
      chk("rfd_low", rfd_w[idx], 1'b0);
    end
    dav_n[idx] = 1'b1;
    avg_s[idx] = 8'($urandom);
    win[idx][n_win[idx]] = val;
    n_win[idx]++;
    cyc();
    if (n_win[idx] == wof(idx)) begin
      mx = win[idx][0];
      mn = win[idx][0];
      for (int unsigned i = 1; i < n_win[idx]; i++) begin
        if (win[idx][i] > mx) mx = win[idx][i];
        if (win[idx][i] < mn) mn = win[idx][i];
      end
      exp_max[idx]  = mx;
      exp_min[idx]  = mn;
      exp_span[idx] = mx - mn;
      n_win[idx]    = 0;
      chk("dav_out_low", dav_out_w[idx], 1'b0);
      chk("rfd_held", rfd_w[idx], 1'b0);
    end else begin
      chk("rfd_back", rfd_w[idx], 1'b1);
      chk("dav_out_idle", dav_out_w[idx], 1'b1);
    end
    chk_outs(idx);
  endtask

  // Downstream side: optionally stall with rfd_out high, optionally poking
  // upstream with avg=77 meanwhile, then complete the handshake.
  task automatic drain(input int idx, input int unsigned stall, input bit poke);
    for (int unsigned s = 0; s < stall; s++) begin
      if (poke) begin
        dav_n[idx] = 1'b0;
        avg_s[idx] = 8'd77;
      end
      cyc();
      chk("stall_dav_out", dav_out_w[idx], 1'b0);
      chk("stall_rfd", rfd_w[idx], 1'b0);
      chk_outs(idx);
    end
    rfd_out_s[idx] = 1'b0;
    cyc();
    chk("dav_out_release", dav_out_w[idx], 1'b1);
    chk("rfd_in_done", rfd_w[idx], 1'b0);
    chk_outs(idx);
    rfd_out_s[idx] = 1'b1;
    cyc();
    chk("rfd_reopen", rfd_w[idx], 1'b1);
    chk("dav_out_idle2", dav_out_w[idx], 1'b1);
    chk_outs(idx);
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < 2; i++) begin
      chk("rst_rfd", rfd_w[i], 1'b1);
      chk("rst_dav_out", dav_out_w[i], 1'b1);
      chk_outs(i);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_    = 1'b0;
    dav_n     = '0;
    avg_s     = '0;
    rfd_out_s = '1;
    model_reset();
    cyc();
    cyc();
    cyc();
    check_reset_state();
    dav_n  = '1;
    reset_ = 1'b1;
    cyc();

    send(0, 8'd10, 1);
    send(0, 8'd200, 1);
    send(0, 8'd55, 1);
    send(0, 8'd200, 1);
    chk("dir_max", max_w[0], 8'd200);
    chk("dir_span", span_w[0], 8'd190);
    drain(0, 0, 1'b0);

    for (int i = 0; i < 4; i++) send(0, 8'($urandom), 1);
    drain(0, 20, 1'b1);
    send(0, 8'd77, 1);
    for (int i = 0; i < 3; i++) send(0, 8'($urandom), 1);
    drain(0, 1, 1'b0);

    send(0, 8'd5, 1);
    send(0, 8'd9, 1);
    reset_ = 1'b0;
    cyc();
    reset_ = 1'b1;
    model_reset();
    check_reset_state();
    for (int i = 0; i < 4; i++) send(0, 8'(100 + i), 1);
    chk("rstmid_span", span_w[0], 8'd3);
    drain(0, 0, 1'b0);

    send(1, 8'd0, 1);
    drain(1, 0, 1'b0);
    send(1, 8'd255, 1);
    chk("w1_max", max_w[1], 8'd255);
    chk("w1_span", span_w[1], 8'd0);
    drain(1, 2, 1'b0);

    for (int i = 0; i < 4; i++) send(0, 8'd128, 1);
    drain(0, 0, 1'b0);

    send(0, 8'd42, 1);
    send(0, 8'd17, 5);
    send(0, 8'd99, 1);
    send(0, 8'd3, 2);
    drain(0, 0, 1'b0);

    for (int w = 0; w < 25; w++) begin
      for (int unsigned i = 0; i < W0; i++) begin
        repeat ($urandom_range(0, 2)) cyc();
        send(0, 8'($urandom), $urandom_range(1, 4));
      end
      drain(0, $urandom_range(0, 3), 1'b0);
    end
    for (int w = 0; w < 10; w++) begin
      send(1, 8'($urandom), $urandom_range(1, 3));
      drain(1, $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
